// File: rtl/acc_icb_pkg.sv
// Shared types and register map for the matrix-accelerator ICB driver.
// Holds the FSM and step encodings plus the STAT/CONFIG/BASERDADDR offsets.
package acc_icb_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_RSP,
    S_GAP,
    S_FINISH
  } state_e;

  typedef enum logic [2:0] {
    STEP_CFG,
    STEP_BASE,
    STEP_GO,
    STEP_CLR,
    STEP_POLL
  } step_e;

  localparam logic [31:0] STAT_OFS = 32'h0;
  localparam logic [31:0] CFG_OFS  = 32'h4;
  localparam logic [31:0] BASE_OFS = 32'h8;

  localparam int STAT_START_BIT = 0;
  localparam int STAT_DONE_BIT  = 0;

endpackage

// File: rtl/acc_icb_driver.sv
// ICB initiator that programs the accelerator and polls STAT until done.
// Define ACC_ICB_DRV_TIMEOUT_EN to abort polling after MAX_POLLS reads.
module acc_icb_driver
  import acc_icb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h1004_2000,
  parameter int          POLL_GAP  = 4,
  parameter int          MAX_POLLS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] cfg_word,
  input  logic [31:0] base_word,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        timeout,
  output logic [15:0] poll_count,
  output logic        icb_cmd_valid,
  input  logic        icb_cmd_ready,
  output logic        icb_cmd_read,
  output logic [31:0] icb_cmd_addr,
  output logic [31:0] icb_cmd_wdata,
  output logic [3:0]  icb_cmd_wmask,
  input  logic        icb_rsp_valid,
  output logic        icb_rsp_ready,
  input  logic [31:0] icb_rsp_rdata,
  input  logic        icb_rsp_err
);

  state_e      state;
  step_e       step;
  logic [31:0] cfg_q;
  logic [31:0] base_q;
  logic        err_q;
  logic        timeout_q;
  logic [15:0] gap_cnt;
  logic        poll_limit_hit;

`ifdef ACC_ICB_DRV_TIMEOUT_EN
  assign poll_limit_hit =
    {16'd0, poll_count} >= 32'(MAX_POLLS);
`else
  logic unused_max_polls;
  assign unused_max_polls = (MAX_POLLS != 0);
  assign poll_limit_hit   = 1'b0;
`endif

  logic unused_rdata;
  assign unused_rdata = ^icb_rsp_rdata[31:1];

  assign busy          = (state != S_IDLE);
  assign done          = (state == S_FINISH);
  assign err           = err_q;
  assign timeout       = timeout_q;
  assign icb_cmd_valid = (state == S_CMD);
  assign icb_rsp_ready = (state == S_RSP);

  // Fields decode from registered step/captures, so they hold until handshake.
  always_comb begin
    icb_cmd_read  = 1'b0;
    icb_cmd_addr  = '0;
    icb_cmd_wdata = '0;
    icb_cmd_wmask = 4'h0;
    if (state == S_CMD) begin
      unique case (1'b1)
        (step == STEP_CFG): begin
          icb_cmd_addr  = BASE_ADDR + CFG_OFS;
          icb_cmd_wdata = cfg_q;
          icb_cmd_wmask = 4'hF;
        end
        (step == STEP_BASE): begin
          icb_cmd_addr  = BASE_ADDR + BASE_OFS;
          icb_cmd_wdata = base_q;
          icb_cmd_wmask = 4'hF;
        end
        (step == STEP_GO): begin
          icb_cmd_addr  = BASE_ADDR + STAT_OFS;
          icb_cmd_wdata = 32'd1 << STAT_START_BIT;
          icb_cmd_wmask = 4'hF;
        end
        (step == STEP_CLR): begin
          icb_cmd_addr  = BASE_ADDR + STAT_OFS;
          icb_cmd_wmask = 4'hF;
        end
        (step == STEP_POLL): begin
          icb_cmd_addr = BASE_ADDR + STAT_OFS;
          icb_cmd_read = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      step       <= STEP_CFG;
      cfg_q      <= '0;
      base_q     <= '0;
      err_q      <= 1'b0;
      timeout_q  <= 1'b0;
      poll_count <= '0;
      gap_cnt    <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            cfg_q      <= cfg_word;
            base_q     <= base_word;
            err_q      <= 1'b0;
            timeout_q  <= 1'b0;
            poll_count <= '0;
            step       <= STEP_CFG;
            state      <= S_CMD;
          end
        end
        S_CMD: begin
          if (icb_cmd_ready) begin
            if (step == STEP_POLL && poll_count != 16'hFFFF)
              poll_count <= poll_count + 16'd1;
            state <= S_RSP;
          end
        end
        S_RSP: begin
          if (icb_rsp_valid) begin
            if (icb_rsp_err) begin
              err_q <= 1'b1;
              state <= S_FINISH;
            end else if (step != STEP_POLL) begin
              step  <= step_e'(step + 3'd1);
              state <= S_CMD;
            end else if (icb_rsp_rdata[STAT_DONE_BIT]) begin
              state <= S_FINISH;
            end else if (poll_limit_hit) begin
              timeout_q <= 1'b1;
              state     <= S_FINISH;
            end else if (POLL_GAP == 0) begin
              state <= S_CMD;
            end else begin
              gap_cnt <= 16'(POLL_GAP - 1);
              state   <= S_GAP;
            end
          end
        end
        S_GAP: begin
          if (gap_cnt == 16'd0) state <= S_CMD;
          else gap_cnt <= gap_cnt - 16'd1;
        end
        S_FINISH: state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_acc_icb_driver.sv
// Directed bench for acc_icb_driver with a behavioural ICB slave
// and a queue of expected commands.
module tb_acc_icb_driver;

  localparam logic [31:0] A   = 32'h1004_2000;
  localparam int          GAP = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] cfg_word = '0;
  logic [31:0] base_word = '0;
  logic        busy, done, err, timeout;
  logic [15:0] poll_count;
  logic        icb_cmd_valid, icb_cmd_read;
  logic        icb_cmd_ready = 1'b0;
  logic [31:0] icb_cmd_addr, icb_cmd_wdata;
  logic [3:0]  icb_cmd_wmask;
  logic        icb_rsp_valid = 1'b0;
  logic        icb_rsp_ready;
  logic [31:0] icb_rsp_rdata = '0;
  logic        icb_rsp_err = 1'b0;

  acc_icb_driver #(
    .BASE_ADDR(A),
    .POLL_GAP (GAP),
    .MAX_POLLS(3)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .cfg_word     (cfg_word),
    .base_word    (base_word),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .timeout      (timeout),
    .poll_count   (poll_count),
    .icb_cmd_valid(icb_cmd_valid),
    .icb_cmd_ready(icb_cmd_ready),
    .icb_cmd_read (icb_cmd_read),
    .icb_cmd_addr (icb_cmd_addr),
    .icb_cmd_wdata(icb_cmd_wdata),
    .icb_cmd_wmask(icb_cmd_wmask),
    .icb_rsp_valid(icb_rsp_valid),
    .icb_rsp_ready(icb_rsp_ready),
    .icb_rsp_rdata(icb_rsp_rdata),
    .icb_rsp_err  (icb_rsp_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rd;
    logic [3:0]  mask;
  } txn_t;

  txn_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   c0 = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // slave knobs, written by the stimulus half a cycle away from the slave
  int          stall_at = -1, stall_left = 0;
  int          err_at = -1, done_at = 1;
  int          reads = 0, hs_idx = 0, prev_rd = -1;
  bit          pend = 1'b0, have_snap = 1'b0;
  logic        pend_err;
  logic [31:0] pend_data;
  logic [68:0] snap;

  always @(negedge clk) begin
    if (rst) begin
      icb_cmd_ready = 1'b0;
      icb_rsp_valid = 1'b0;
      icb_rsp_err   = 1'b0;
      pend          = 1'b0;
      have_snap     = 1'b0;
    end else begin
      icb_rsp_valid = 1'b0;
      icb_rsp_err   = 1'b0;
      icb_rsp_rdata = $urandom;
      if (pend) begin
        icb_rsp_valid = 1'b1;
        icb_rsp_err   = pend_err;
        icb_rsp_rdata = pend_data;
        pend          = 1'b0;
      end
      icb_cmd_ready = 1'b0;
      if (icb_cmd_valid) begin
        chk("rsp_ready_in_cmd", {31'd0, icb_rsp_ready}, 32'd0);
        if (!have_snap) begin
          snap = {icb_cmd_addr, icb_cmd_wdata,
                  icb_cmd_read, icb_cmd_wmask};
          have_snap = 1'b1;
        end else begin
          chk("stable_addr", icb_cmd_addr, snap[68:37]);
          chk("stable_wdata", icb_cmd_wdata, snap[36:5]);
          chk("stable_rw", {27'd0, icb_cmd_read, icb_cmd_wmask},
              {27'd0, snap[4:0]});
        end
        if (hs_idx == stall_at && stall_left > 0) begin
          stall_left--;
        end else begin
          icb_cmd_ready = 1'b1;
          have_snap     = 1'b0;
          n_tests++;
          assert (exp_q.size() != 0) else begin
            n_fail++;
            $error("FAIL extra_cmd: got cmd addr %0h, expected none",
                   icb_cmd_addr);
          end
          if (exp_q.size() != 0) begin
            txn_t e;
            e = exp_q.pop_front();
            chk("cmd_addr", icb_cmd_addr, e.addr);
            chk("cmd_rw", {27'd0, icb_cmd_read, icb_cmd_wmask},
                {27'd0, e.rd, e.mask});
            if (!e.rd) chk("cmd_wdata", icb_cmd_wdata, e.wdata);
          end
          pend_data = $urandom;
          pend_data[0] = 1'b0;
          if (icb_cmd_read) begin
            reads++;
            if (prev_rd >= 0) chk("poll_gap", cyc - prev_rd, 2 + GAP);
            prev_rd = cyc;
            pend_data[0] = (done_at != 0 && reads >= done_at);
          end
          pend_err = (hs_idx == err_at);
          pend     = 1'b1;
          hs_idx++;
        end
      end
    end
  end

  task automatic step_cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic new_seq();
    hs_idx  = 0;
    reads   = 0;
    prev_rd = -1;
  endtask

  task automatic push_w(input logic [31:0] ofs, input logic [31:0] d);
    exp_q.push_back('{A + ofs, d, 1'b0, 4'hF});
  endtask

  task automatic push_seq(input logic [31:0] c, input logic [31:0] b,
                          input int n);
    push_w(32'h4, c);
    push_w(32'h8, b);
    push_w(32'h0, 32'd1);
    push_w(32'h0, 32'd0);
    for (int i = 0; i < n; i++) exp_q.push_back('{A, 32'd0, 1'b1, 4'h0});
  endtask

  task automatic start_seq(input logic [31:0] c, input logic [31:0] b);
    cfg_word  = c;
    base_word = b;
    start     = 1'b1;
    c0        = cyc;
    step_cyc();
    start     = 1'b0;
    cfg_word  = $urandom;
    base_word = $urandom;
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int i = 0; i < 400; i++) begin
      if (done) begin
        lat = cyc - c0;
        break;
      end
      step_cyc();
    end
  endtask

  task automatic finish_checks(input int exp_lat, input int lat,
                               input int polls, input logic e,
                               input logic t);
    chk("done_latency", lat, exp_lat);
    chk("poll_count", {16'd0, poll_count}, polls);
    chk("err", {31'd0, err}, {31'd0, e});
    chk("timeout", {31'd0, timeout}, {31'd0, t});
    step_cyc();
    chk("done_pulse_one_cycle", {31'd0, done}, 32'd0);
    chk("busy_after_done", {31'd0, busy}, 32'd0);
    chk("err_sticky", {31'd0, err}, {31'd0, e});
    chk("queue_drained", exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    repeat (2) step_cyc();
    chk("rst_cmd_valid", {31'd0, icb_cmd_valid}, 32'd0);
    chk("rst_rsp_ready", {31'd0, icb_rsp_ready}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err_to", {30'd0, err, timeout}, 32'd0);
    chk("rst_poll_count", {16'd0, poll_count}, 32'd0);
    chk("rst_addr", icb_cmd_addr, 32'd0);
    chk("rst_wdata", icb_cmd_wdata, 32'd0);
    chk("rst_rw", {27'd0, icb_cmd_read, icb_cmd_wmask}, 32'd0);
    rst = 1'b0;
    step_cyc();

    // basic sequence, done on first poll
    new_seq();
    done_at = 1;
    push_seq(32'h0808_0801, 32'h0010_0000, 1);
    start_seq(32'h0808_0801, 32'h0010_0000);
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    chk("first_cmd_valid", {31'd0, icb_cmd_valid}, 32'd1);
    wait_done(lat);
    finish_checks(11, lat, 1, 1'b0, 1'b0);

    // five polls; a start while busy is ignored
    new_seq();
    done_at = 5;
    push_seq(32'hCAFE_0001, 32'h0ABC_0123, 5);
    start_seq(32'hCAFE_0001, 32'h0ABC_0123);
    step_cyc();
    start    = 1'b1;
    cfg_word = 32'hDEAD_BEEF;
    step_cyc();
    start    = 1'b0;
    wait_done(lat);
    finish_checks(35, lat, 5, 1'b0, 1'b0);

    // slave stalls step 1 for three cycles
    new_seq();
    done_at    = 1;
    stall_at   = 1;
    stall_left = 3;
    push_seq(32'h1234_5678, 32'h0FFF_0FFF, 1);
    start_seq(32'h1234_5678, 32'h0FFF_0FFF);
    wait_done(lat);
    finish_checks(14, lat, 1, 1'b0, 1'b0);
    stall_at = -1;

    // error response on step 2 aborts before the STAT clear
    new_seq();
    err_at = 2;
    push_w(32'h4, 32'h0000_0101);
    push_w(32'h8, 32'h0002_0003);
    push_w(32'h0, 32'd1);
    start_seq(32'h0000_0101, 32'h0002_0003);
    wait_done(lat);
    finish_checks(7, lat, 0, 1'b1, 1'b0);
    err_at = -1;

`ifdef ACC_ICB_DRV_TIMEOUT_EN
    new_seq();
    done_at = 0;
    push_seq(32'h5555_AAAA, 32'h0001_0001, 3);
    start_seq(32'h5555_AAAA, 32'h0001_0001);
    wait_done(lat);
    finish_checks(23, lat, 3, 1'b0, 1'b1);
    done_at = 1;
`endif

    // reset while waiting on the step-2 response
    new_seq();
    done_at = 1;
    push_seq(32'h0F0F_0F0F, 32'h0300_0400, 1);
    start_seq(32'h0F0F_0F0F, 32'h0300_0400);
    for (int i = 0; i < 50 && hs_idx < 3; i++) step_cyc();
    chk("reached_step2", hs_idx, 32'd3);
    step_cyc();
    chk("in_rsp_step2", {31'd0, icb_rsp_ready}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_mid_cmd_valid", {31'd0, icb_cmd_valid}, 32'd0);
    chk("rst_mid_rsp_ready", {31'd0, icb_rsp_ready}, 32'd0);
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_left", exp_q.size(), 32'd2);
    exp_q.delete();
    repeat (2) step_cyc();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step_cyc();
      chk("post_rst_quiet", {30'd0, icb_cmd_valid, done}, 32'd0);
    end
    new_seq();
    push_seq(32'h7777_0001, 32'h0100_0200, 1);
    start_seq(32'h7777_0001, 32'h0100_0200);
    wait_done(lat);
    finish_checks(11, lat, 1, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
